// File: rtl/mem_stage_if.sv
// Data-memory port of the MEM stage: one request at a time, held until d_ack.
// The master side belongs to the pipeline and the slave side to the memory.
interface mem_stage_if;
    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [3:0]  d_be;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;

    modport master (
        output d_req, d_we, d_addr, d_be, d_wdata,
        input  d_ack, d_rdata
    );

    modport slave (
        input  d_req, d_we, d_addr, d_be, d_wdata,
        output d_ack, d_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline MEM stage: runs loads/stores on a req/ack data port, forwards results to EX,
// registers them for writeback and stalls upstream while an access is outstanding.
module mem_stage #(
    parameter int WAIT_LIMIT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] res_EX,
    input  logic [31:0] x2_EX,
    input  logic [4:0]  rd_EX,
    input  logic [6:0]  opcode_EX,
    input  logic [2:0]  funct3_EX,
    mem_stage_if.master dmem,
    output logic [4:0]  rd_MEM,
    output logic [31:0] res_MEM,
    output logic [4:0]  rd_WB,
    output logic [31:0] res_WB,
    output logic        stall,
    output logic        mem_err
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam int         CNT_W    = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_LIMIT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // EX/MEM register
    logic [31:0] res_q;
    logic [31:0] x2_q;
    logic [4:0]  rd_q;
    logic [6:0]  op_q;
    logic [2:0]  f3_q;

    logic [CNT_W-1:0] cnt_q;
    logic [31:0]      ld_q;
    logic [31:0]      ld_ext;
    logic [31:0]      ld_shift;
    logic [3:0]       be;
    logic [31:0]      wdata;
    logic             ld_we;
    logic             in_req;
    logic             q_store;
    logic             q_mis;
    logic             ex_access;
    state_t           adv_state;

    function automatic logic is_mem(input logic [6:0] op);
        return (op == OP_LOAD) || (op == OP_STORE);
    endfunction

    // Halves need an even address; words (and the unused size code 11) need a 4-byte boundary.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        logic m;
        case (f3[1:0])
            2'b00:   m = 1'b0;
            2'b01:   m = a[0];
            default: m = |a;
        endcase
        return m;
    endfunction

    assign q_store   = (op_q == OP_STORE);
    assign q_mis     = is_mem(op_q) && misaligned(f3_q, res_q[1:0]);
    assign ex_access = is_mem(opcode_EX) && !misaligned(funct3_EX, res_EX[1:0]);
    assign adv_state = ex_access ? REQ : IDLE;
    assign in_req    = (state_q == REQ);

    // Store lanes and byte enables follow the low address bits of the captured access.
    always_comb begin
        be    = 4'b1111;
        wdata = x2_q;
        case (f3_q[1:0])
            2'b00: begin
                be    = 4'b0001 << res_q[1:0];
                wdata = {4{x2_q[7:0]}};
            end
            2'b01: begin
                be    = res_q[1] ? 4'b1100 : 4'b0011;
                wdata = {2{x2_q[15:0]}};
            end
            default: ;
        endcase
    end

    assign ld_shift = dmem.d_rdata >> {res_q[1:0], 3'b000};

    always_comb begin
        case (f3_q)
            3'b000:  ld_ext = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_ext = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_ext = {24'd0, ld_shift[7:0]};
            3'b101:  ld_ext = {16'd0, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    assign dmem.d_req   = in_req;
    assign dmem.d_we    = in_req && q_store;
    assign dmem.d_addr  = in_req ? {res_q[31:2], 2'b00} : 32'd0;
    assign dmem.d_be    = in_req ? be : 4'd0;
    assign dmem.d_wdata = in_req ? wdata : 32'd0;

    // NOTE: every output of this block gets a default before the case so no path leaves
    // a signal unassigned; a missing default would infer a latch.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        mem_err = 1'b0;
        ld_we   = 1'b0;
        rd_MEM  = rd_q;
        res_MEM = res_q;
        case (state_q)
            IDLE: begin
                if (q_mis) begin
                    rd_MEM  = 5'd0;
                    mem_err = 1'b1;
                end
                state_d = adv_state;
            end
            REQ: begin
                rd_MEM = 5'd0;
                stall  = 1'b1;
                if (dmem.d_ack) begin
                    if (q_store) begin
                        stall   = 1'b0;
                        state_d = adv_state;
                    end else begin
                        ld_we   = 1'b1;
                        state_d = DONE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    // Timeout: drop the access and let the pipeline move on with no writeback.
                    stall   = 1'b0;
                    mem_err = 1'b1;
                    state_d = adv_state;
                end
            end
            DONE: begin
                res_MEM = ld_q;
                state_d = adv_state;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: state is updated with non-blocking assignments so every register samples
    // the values from before this edge, regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            res_q   <= 32'd0;
            x2_q    <= 32'd0;
            rd_q    <= 5'd0;
            op_q    <= 7'd0;
            f3_q    <= 3'd0;
            cnt_q   <= '0;
            ld_q    <= 32'd0;
            rd_WB   <= 5'd0;
            res_WB  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (!stall) begin
                res_q  <= res_EX;
                x2_q   <= x2_EX;
                rd_q   <= rd_EX;
                op_q   <= opcode_EX;
                f3_q   <= funct3_EX;
                rd_WB  <= rd_MEM;
                res_WB <= res_MEM;
            end else begin
                rd_WB <= 5'd0;
            end
            if (ld_we) begin
                ld_q <= ld_ext;
            end
            cnt_q <= (in_req && stall) ? cnt_q + 1'b1 : '0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios followed by random instruction
// streams, compared against a transaction-level model of the MEM stage.
module tb_mem_stage;

    localparam int WAIT_LIMIT = 16;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;
    localparam int NEVER = 1000;

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [31:0] res;
        logic [31:0] x2;
        logic [4:0]  rd;
        int          delay;   // REQ cycles before the memory acks
        logic [31:0] rdata;
    } instr_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] val;
    } wb_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] res_EX, x2_EX;
    logic [4:0]  rd_EX;
    logic [6:0]  opcode_EX;
    logic [2:0]  funct3_EX;
    logic [4:0]  rd_MEM, rd_WB;
    logic [31:0] res_MEM, res_WB;
    logic        stall, mem_err;

    mem_stage_if dmem ();

    mem_stage #(.WAIT_LIMIT(WAIT_LIMIT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .res_EX    (res_EX),
        .x2_EX     (x2_EX),
        .rd_EX     (rd_EX),
        .opcode_EX (opcode_EX),
        .funct3_EX (funct3_EX),
        .dmem      (dmem.master),
        .rd_MEM    (rd_MEM),
        .res_MEM   (res_MEM),
        .rd_WB     (rd_WB),
        .res_WB    (res_WB),
        .stall     (stall),
        .mem_err   (mem_err)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    instr_t prog[$];
    instr_t acc_q[$];
    wb_t    wb_q[$];
    instr_t cur, last_in;
    bit     cur_from_prog;
    int     req_k, stall_cnt, err_seen;
    bit     mis_pend, alu_pend, done_pend, saw_req;
    wb_t    done_exp;
    logic [31:0] done_res;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic instr_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] res,
                                  input logic [31:0] x2, input logic [4:0] rd, input int delay,
                                  input logic [31:0] rdata);
        instr_t i;
        i.op = op; i.f3 = f3; i.res = res; i.x2 = x2; i.rd = rd; i.delay = delay; i.rdata = rdata;
        return i;
    endfunction

    function automatic instr_t nop();
        return mk(OP_ALU, 3'd0, 32'd0, 32'd0, 5'd0, 0, 32'd0);
    endfunction

    function automatic bit is_mem(input instr_t i);
        return (i.op == OP_LOAD) || (i.op == OP_STORE);
    endfunction

    function automatic bit is_mis(input instr_t i);
        int a = int'(i.res[1:0]);
        if (!is_mem(i)) return 1'b0;
        if (i.f3[1:0] == 2'b01) return (a % 2) != 0;
        if (i.f3[1:0] == 2'b10) return a != 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] exp_be(input instr_t i);
        int a = int'(i.res[1:0]);
        if (i.f3[1:0] == 2'b00) return 4'(1 << a);
        if (i.f3[1:0] == 2'b01) return 4'(3 << (a & 2));
        return 4'hF;
    endfunction

    function automatic logic [31:0] exp_wdata(input instr_t i);
        if (i.f3[1:0] == 2'b00) return (i.x2 & 32'hFF) * 32'h0101_0101;
        if (i.f3[1:0] == 2'b01) return (i.x2 & 32'hFFFF) * 32'h0001_0001;
        return i.x2;
    endfunction

    function automatic logic [31:0] exp_load(input instr_t i);
        logic [31:0] w = i.rdata >> (8 * int'(i.res[1:0]));
        case (i.f3)
            3'd0:    return ((w & 32'hFF) ^ 32'h80) - 32'h80;
            3'd1:    return ((w & 32'hFFFF) ^ 32'h8000) - 32'h8000;
            3'd4:    return w & 32'hFF;
            3'd5:    return w & 32'hFFFF;
            default: return w;
        endcase
    endfunction

    function automatic instr_t rand_instr();
        logic [2:0] ld_f3[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
        instr_t i;
        int k = int'($urandom_range(0, 9));
        i.res   = $urandom;
        i.x2    = $urandom;
        i.rd    = 5'($urandom_range(0, 31));
        i.rdata = $urandom;
        i.delay = int'($urandom_range(0, 4));
        if ($urandom_range(0, 24) == 0) i.delay = NEVER;
        if (k < 4) begin
            i.op = ($urandom_range(0, 1) == 0) ? OP_ALU : 7'b0010011;
            i.f3 = 3'($urandom_range(0, 7));
        end else if (k < 7) begin
            i.op = OP_LOAD;
            i.f3 = ld_f3[$urandom_range(0, 4)];
        end else begin
            i.op = OP_STORE;
            i.f3 = 3'($urandom_range(0, 2));
        end
        if (i.op != OP_ALU && $urandom_range(0, 4) != 0) begin
            if (i.f3[1:0] == 2'b01) i.res[0] = 1'b0;
            if (i.f3[1:0] == 2'b10) i.res[1:0] = 2'b00;
        end
        return i;
    endfunction

    task automatic apply();
        res_EX = cur.res; x2_EX = cur.x2; rd_EX = cur.rd; opcode_EX = cur.op; funct3_EX = cur.f3;
    endtask

    // Compares one settled cycle against the model and retires what the next edge consumes.
    task automatic observe(output bit consumed);
        bit   abort = 1'b0;
        logic exp_err = mis_pend;
        consumed = 1'b0;
        saw_req  = saw_req | dmem.d_req;
        check("d_req", 32'(dmem.d_req), 32'(acc_q.size() != 0));
        if (mis_pend) check("mis_rd_mem", 32'(rd_MEM), 32'd0);
        if (alu_pend) begin
            check("alu_rd_mem", 32'(rd_MEM), 32'(last_in.rd));
            check("alu_res_mem", res_MEM, last_in.res);
        end
        if (done_pend) begin
            check("done_stall", 32'(stall), 32'd0);
            check("done_rd_mem", 32'(rd_MEM), 32'(done_exp.rd));
            check("done_res_mem", res_MEM, done_exp.val);
            done_res = res_MEM;
        end
        mis_pend = 1'b0; alu_pend = 1'b0; done_pend = 1'b0;
        if (rd_WB != 5'd0) begin
            if (wb_q.size() == 0) begin
                check("wb_unexpected", 32'(rd_WB), 32'd0);
            end else begin
                wb_t w = wb_q.pop_front();
                check("wb_rd", 32'(rd_WB), 32'(w.rd));
                check("wb_res", res_WB, w.val);
            end
        end
        if (dmem.d_req && acc_q.size() != 0) begin
            instr_t a = acc_q[0];
            check("d_we", 32'(dmem.d_we), 32'(a.op == OP_STORE));
            check("d_addr", dmem.d_addr, a.res & 32'hFFFF_FFFC);
            if (a.op == OP_STORE) begin
                check("d_be", 32'(dmem.d_be), 32'(exp_be(a)));
                check("d_wdata", dmem.d_wdata, exp_wdata(a));
            end
            check("req_rd_mem", 32'(rd_MEM), 32'd0);
            if (stall) stall_cnt++;
            if (dmem.d_ack) begin
                check("stall_cycles", 32'(stall_cnt), 32'((a.op == OP_STORE) ? a.delay : a.delay + 1));
                if (a.op == OP_LOAD) begin
                    done_exp.rd  = a.rd;
                    done_exp.val = exp_load(a);
                    done_pend    = 1'b1;
                    if (a.rd != 5'd0) wb_q.push_back(done_exp);
                end
                void'(acc_q.pop_front());
                req_k = 0; stall_cnt = 0;
            end else if (req_k == WAIT_LIMIT - 1) begin
                abort = 1'b1;
                check("abort_stall_cycles", 32'(stall_cnt), 32'(WAIT_LIMIT - 1));
                void'(acc_q.pop_front());
                req_k = 0; stall_cnt = 0;
            end else begin
                req_k++;
            end
        end else begin
            check("stall_idle", 32'(stall), 32'd0);
        end
        check("mem_err", 32'(mem_err), 32'(exp_err | abort));
        if (mem_err) err_seen++;
        if (!stall) begin
            consumed = 1'b1;
            last_in  = cur;
            if (is_mem(cur) && !is_mis(cur)) acc_q.push_back(cur);
            else if (is_mem(cur)) mis_pend = 1'b1;
            else begin
                alu_pend = 1'b1;
                if (cur.rd != 5'd0) wb_q.push_back('{cur.rd, cur.res});
            end
        end
    endtask

    task automatic cycle();
        bit consumed;
        @(negedge clk);
        dmem.d_ack = 1'b0;
        dmem.d_rdata = $urandom;
        if (dmem.d_req && acc_q.size() != 0 && req_k == acc_q[0].delay) begin
            dmem.d_ack   = 1'b1;
            dmem.d_rdata = acc_q[0].rdata;
        end
        #1;
        observe(consumed);
        @(posedge clk);
        #1;
        if (consumed) begin
            cur_from_prog = (prog.size() != 0);
            cur = cur_from_prog ? prog.pop_front() : nop();
            apply();
        end
    endtask

    task automatic drain();
        int guard = 0;
        while ((prog.size() != 0 || acc_q.size() != 0 || cur_from_prog) && guard < 20000) begin
            cycle();
            guard++;
        end
        check("drain_done", 32'(prog.size() + acc_q.size()), 32'd0);
        repeat (3) cycle();
    endtask

    initial begin
        dmem.d_ack = 1'b0;
        dmem.d_rdata = 32'd0;
        cur = mk(OP_ALU, 3'd0, 32'hCAFE, 32'd0, 5'd3, 0, 32'd0);
        apply();
        repeat (3) @(posedge clk);
        #1;
        check("rst_d_req", 32'(dmem.d_req), 32'd0);
        check("rst_d_we", 32'(dmem.d_we), 32'd0);
        check("rst_d_be", 32'(dmem.d_be), 32'd0);
        check("rst_d_addr", dmem.d_addr, 32'd0);
        check("rst_d_wdata", dmem.d_wdata, 32'd0);
        check("rst_rd_mem", 32'(rd_MEM), 32'd0);
        check("rst_res_mem", res_MEM, 32'd0);
        check("rst_rd_wb", 32'(rd_WB), 32'd0);
        check("rst_res_wb", res_WB, 32'd0);
        check("rst_stall", 32'(stall), 32'd0);
        check("rst_mem_err", 32'(mem_err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cur = nop(); cur_from_prog = 1'b0;
        apply();

        // ALU pass-through, then SB with ack after three wait cycles
        prog.push_back(mk(OP_ALU, 3'd0, 32'h1234, 32'd0, 5'd5, 0, 32'd0));
        prog.push_back(mk(OP_STORE, 3'd0, 32'h103, 32'hAB, 5'd0, 3, 32'd0));
        drain();

        // LB / LBU sign and zero extension
        prog.push_back(mk(OP_LOAD, 3'd0, 32'h102, 32'd0, 5'd4, 0, 32'h0080_0000));
        drain();
        check("lb_sext", done_res, 32'hFFFF_FF80);
        prog.push_back(mk(OP_LOAD, 3'd4, 32'h102, 32'd0, 5'd4, 0, 32'h0080_0000));
        drain();
        check("lbu_zext", done_res, 32'h0000_0080);

        // LW x7 followed by a dependent instruction
        prog.push_back(mk(OP_LOAD, 3'd2, 32'h300, 32'd0, 5'd7, 2, 32'h1357_9BDF));
        prog.push_back(mk(OP_ALU, 3'd0, 32'h1357_9BE0, 32'd0, 5'd8, 0, 32'd0));
        drain();
        check("lw_fwd", done_res, 32'h1357_9BDF);

        // misaligned LH, then a LW the memory never acks
        err_seen = 0;
        prog.push_back(mk(OP_LOAD, 3'd1, 32'h201, 32'd0, 5'd6, 0, 32'd0));
        prog.push_back(mk(OP_LOAD, 3'd2, 32'h400, 32'd0, 5'd9, NEVER, 32'd0));
        drain();
        check("err_pulses", 32'(err_seen), 32'd2);

        // async reset in the middle of an access, then a stale ack
        saw_req = 1'b0;
        prog.push_back(mk(OP_LOAD, 3'd2, 32'h500, 32'd0, 5'd10, NEVER, 32'd0));
        for (int g = 0; g < 20 && !saw_req; g++) cycle();
        check("reset_req_seen", 32'(saw_req), 32'd1);
        cycle();
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_mid_d_req", 32'(dmem.d_req), 32'd0);
        check("rst_mid_stall", 32'(stall), 32'd0);
        check("rst_mid_rd_mem", 32'(rd_MEM), 32'd0);
        check("rst_mid_rd_wb", 32'(rd_WB), 32'd0);
        acc_q.delete(); wb_q.delete(); prog.delete();
        req_k = 0; stall_cnt = 0; mis_pend = 1'b0; alu_pend = 1'b0; done_pend = 1'b0;
        cur = nop(); cur_from_prog = 1'b0;
        apply();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        dmem.d_ack = 1'b1;
        dmem.d_rdata = 32'hDEAD_BEEF;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            #1;
            check("stale_d_req", 32'(dmem.d_req), 32'd0);
            check("stale_rd_wb", 32'(rd_WB), 32'd0);
            check("stale_stall", 32'(stall), 32'd0);
        end
        dmem.d_ack = 1'b0;

        // random instruction stream
        for (int n = 0; n < 600; n++) prog.push_back(rand_instr());
        drain();
        check("wb_leftover", 32'(wb_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
